scandoubler: RTL and testbench

Converts the 15 kHz RGB/sync stream from the screen controller into a 31 kHz progressive stream for VGA output. Each incoming line, sampled at the 7 MHz pixel rate, is written into one bank of a two-line buffer. The previous line is read back twice from the other bank at 14 MHz. The block sits between the screen controller outputs and the board video pins, and a runtime bypass passes the native stream through.

---
 rtl/scandoubler.sv | 90 +++++++++
 tb/tb_scandoubler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scandoubler.sv
// scandoubler: doubles a 15 kHz RGB stream to 31 kHz through a two-bank line buffer, with a bypass path
// Ports: clk28/rst_n (async active-low) clock and reset; ck14/ck7 clock-enable pulses;
//        en selects doubled (1) or bypass (0); r_in/g_in/b_in/hsync_in/vsync_in source video;
//        r/g/b/hsync/vsync registered VGA outputs (syncs active low).
module scandoubler #(
    parameter int ADDR_W    = 9,
    parameter int HSYNC_LEN = 52
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ck14,
    input  logic       ck7,
    input  logic       en,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [5:0] r,
    output logic [5:0] g,
    output logic [5:0] b,
    output logic       hsync,
    output logic       vsync
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W:0]   HS_LEN   = (ADDR_W+1)'(HSYNC_LEN);

    logic [17:0]       mem [2**(ADDR_W+1)];
    logic [17:0]       rd_data_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   line_len_q, line_len_d;
    logic              hs_q, wr_bank_q, wr_bank_d, vs_line_q, vs_line_d;
    logic              hs_p1_q, blank_p1_q, vs_p1_q;
    logic              line_start, rd_wrap, rd_zero;

    assign line_start = hs_q & ~hsync_in;
    // With no captured length the read pointer free-runs over the whole bank
    assign rd_wrap    = (line_len_q == '0) ? (rd_addr_q == ADDR_MAX)
                                           : ({1'b0, rd_addr_q} == line_len_q - 1'b1);
    assign rd_zero    = line_start | (ck14 & rd_wrap);

    always_comb begin
        wr_addr_d  = line_start ? '0 : (ck7 && wr_addr_q != ADDR_MAX) ? wr_addr_q + 1'b1 : wr_addr_q;
        line_len_d = line_start ? {1'b0, wr_addr_q} + {{ADDR_W{1'b0}}, ck7} : line_len_q;
        wr_bank_d  = wr_bank_q ^ line_start;
        rd_addr_d  = rd_zero ? '0 : ck14 ? rd_addr_q + 1'b1 : rd_addr_q;
        vs_line_d  = rd_zero ? vsync_in : vs_line_q;
    end

    // Pixel storage {g,r,b}; a coincident line start still writes to the old bank/address
    always_ff @(posedge clk28) begin
        if (ck7) mem[{wr_bank_q, wr_addr_q}] <= {g_in, r_in, b_in};
        rd_data_q <= mem[{~wr_bank_q, rd_addr_q}];
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            hs_q       <= 1'b1;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            line_len_q <= '0;
            wr_bank_q  <= 1'b0;
            vs_line_q  <= 1'b1;
            hs_p1_q    <= 1'b0;
            blank_p1_q <= 1'b1;
            vs_p1_q    <= 1'b1;
            r          <= '0;
            g          <= '0;
            b          <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
        end else begin
            hs_q       <= hsync_in;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            line_len_q <= line_len_d;
            wr_bank_q  <= wr_bank_d;
            vs_line_q  <= vs_line_d;
            // Sync/blank decisions delayed one stage to line up with the registered RAM data
            hs_p1_q    <= {1'b0, rd_addr_q} < HS_LEN;
            blank_p1_q <= line_len_q == '0;
            vs_p1_q    <= vs_line_q;
            r          <= en ? ((hs_p1_q | blank_p1_q) ? '0 : rd_data_q[11:6]) : r_in;
            g          <= en ? ((hs_p1_q | blank_p1_q) ? '0 : rd_data_q[17:12]) : g_in;
            b          <= en ? ((hs_p1_q | blank_p1_q) ? '0 : rd_data_q[5:0]) : b_in;
            hsync      <= en ? ~hs_p1_q : hsync_in;
            vsync      <= en ? vs_p1_q : vsync_in;
        end
    end
endmodule

// File: tb/tb_scandoubler.sv
// tb_scandoubler: table vectors, hand sequences and random lines checked against a line-level model
module tb_scandoubler;
    localparam int ADDR_W = 9;
    localparam int HSL    = 52;

    logic       clk28 = 0, rst_n = 0, ck14 = 1, ck7 = 1, en = 1;
    logic [5:0] r_in = 0, g_in = 0, b_in = 0;
    logic       hsync_in = 1, vsync_in = 1;
    logic [5:0] r, g, b;
    logic       hsync, vsync;
    int         checks = 0, errors = 0;

    scandoubler #(.ADDR_W(ADDR_W), .HSYNC_LEN(HSL)) dut (
        .clk28(clk28), .rst_n(rst_n), .ck14(ck14), .ck7(ck7), .en(en),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk28 = ~clk28;

    // Model: pixels of the line being captured, the last complete line, its length,
    // and ck14 ticks since the last line start. Output vectors are {r,g,b,hsync,vsync}.
    logic [17:0] cur [512];
    logic [17:0] shown [512];
    int          cnt, len, ticks;
    logic        m_hs, vs_line;
    logic [19:0] p1m, expv;

    int   ph = 0, ncyc = 0, fall_t = -1, last_period = 0, last_low = 0;
    int   line_j = 100000, hs_w = 64, pix = 0;
    logic prev_hs = 1;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, ncyc, got, want);
        end
    endtask

    task automatic model_reset();
        cnt = 0; len = 0; ticks = 0; m_hs = 1; vs_line = 1;
        p1m = 20'h3; expv = 20'h3;
    endtask

    function automatic logic [19:0] view();
        int m = (len == 0) ? 512 : len;
        int pos = ticks % m;
        logic act = pos < HSL;
        return {(act || len == 0) ? 18'd0 : shown[pos], ~act, vs_line};
    endfunction

    task automatic model_edge();
        logic ls;
        if (!rst_n) begin
            model_reset();
            return;
        end
        expv = en ? p1m : {r_in, g_in, b_in, hsync_in, vsync_in};
        p1m  = view();
        ls   = m_hs && !hsync_in;
        m_hs = hsync_in;
        if (ck7) cur[cnt > 511 ? 511 : cnt] = {r_in, g_in, b_in};
        if (ls) begin
            len = (cnt > 511 ? 511 : cnt) + int'(ck7);
            shown = cur; cnt = 0; ticks = 0; vs_line = vsync_in;
        end else begin
            if (ck7) cnt++;
            if (ck14) begin
                ticks++;
                if (ticks % ((len == 0) ? 512 : len) == 0) vs_line = vsync_in;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk28);
        model_edge();
        @(negedge clk28);
        check("out", {12'd0, r, g, b, hsync, vsync}, {12'd0, expv});
        ncyc++;
        if (prev_hs && !hsync) begin
            if (fall_t >= 0) last_period = ncyc - fall_t;
            fall_t = ncyc;
        end
        if (!prev_hs && hsync && fall_t >= 0) last_low = ncyc - fall_t;
        prev_hs = hsync;
        ph = (ph + 1) % 4;
        ck14 = (ph % 2) == 0;
        ck7 = ph == 0;
    endtask

    task automatic new_line(int w);
        line_j = 0; pix = 0; hs_w = w;
    endtask

    task automatic line_cycles(int n);
        logic c7;
        for (int i = 0; i < n; i++) begin
            hsync_in = line_j >= hs_w;
            r_in = pix[5:0]; g_in = 6'($urandom); b_in = 6'($urandom);
            c7 = ck7;
            cyc();
            if (c7 && line_j > 0) pix++;
            line_j++;
        end
    endtask

    task automatic align();
        while (ph != 0) line_cycles(1);
    endtask

    typedef struct {
        logic [5:0] r, g, b;
        logic       hs, vs;
        logic [5:0] er, eg, eb;
        logic       ehs, evs;
    } vec_t;
    vec_t tbl [6];

    initial begin
        int n;
        tbl[0] = '{6'h2A, 6'h00, 6'h00, 1'b0, 1'b1, 6'h2A, 6'h00, 6'h00, 1'b0, 1'b1};
        tbl[1] = '{6'h15, 6'h3F, 6'h01, 1'b1, 1'b1, 6'h15, 6'h3F, 6'h01, 1'b1, 1'b1};
        tbl[2] = '{6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0};
        tbl[3] = '{6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0};
        tbl[4] = '{6'h01, 6'h02, 6'h04, 1'b1, 1'b1, 6'h01, 6'h02, 6'h04, 1'b1, 1'b1};
        tbl[5] = '{6'h2A, 6'h15, 6'h2A, 1'b0, 1'b1, 6'h2A, 6'h15, 6'h2A, 1'b0, 1'b1};
        model_reset();
        repeat (4) cyc();
        check("reset_out", {12'd0, r, g, b, hsync, vsync}, 32'h3);
        rst_n = 1;
        repeat (3) cyc();

        // Bypass: outputs are the inputs one clk28 later
        en = 0;
        for (int i = 0; i < 6; i++) begin
            r_in = tbl[i].r; g_in = tbl[i].g; b_in = tbl[i].b;
            hsync_in = tbl[i].hs; vsync_in = tbl[i].vs;
            cyc();
            check("bypass_rgb", {14'd0, r, g, b}, {14'd0, tbl[i].er, tbl[i].eg, tbl[i].eb});
            check("bypass_sync", {30'd0, hsync, vsync}, {30'd0, tbl[i].ehs, tbl[i].evs});
        end
        hsync_in = 1; vsync_in = 1; en = 1;
        align();

        // Steady 448-pixel lines
        repeat (3) begin new_line(64); line_cycles(1792); end
        new_line(64);
        line_cycles(63);
        check("px30_blank", {13'd0, r, g, b, hsync}, 32'd0);
        line_cycles(140);
        check("px100_first", {26'd0, r}, 32'd36);
        line_cycles(896);
        check("px100_second", {26'd0, r}, 32'd36);
        check("period448", last_period, 896);
        check("hs_low448", last_low, 104);
        line_cycles(1792 - 1099);

        // Reset mid-line: immediate reset values, then black until a line is captured
        new_line(64);
        line_cycles(500);
        rst_n = 0;
        #1;
        check("rst_rgb", {14'd0, r, g, b}, 32'd0);
        check("rst_sync", {30'd0, hsync, vsync}, 32'd3);
        model_reset();
        line_cycles(3);
        rst_n = 1;
        line_cycles(600);
        check("black_after_rst", {14'd0, r, g, b}, 32'd0);
        line_cycles(1792 - 1103);
        repeat (2) begin new_line(64); line_cycles(1792); end

        // Vsync follows only at output line starts
        new_line(64);
        line_cycles(300);
        vsync_in = 0;
        line_cycles(598);
        check("vs_hold_hi", {31'd0, vsync}, 32'd1);
        line_cycles(1);
        check("vs_fall", {31'd0, vsync}, 32'd0);
        line_cycles(893);
        new_line(64);
        line_cycles(300);
        vsync_in = 1;
        line_cycles(598);
        check("vs_hold_lo", {31'd0, vsync}, 32'd0);
        line_cycles(1);
        check("vs_rise", {31'd0, vsync}, 32'd1);
        line_cycles(893);

        // Line length change 448 -> 456
        repeat (2) begin new_line(64); line_cycles(1824); end
        new_line(64);
        line_cycles(1000);
        check("period456", last_period, 912);
        line_cycles(824);

        // Overflow: 600 writes saturate; captured length 512 with coincident ck7, else 511
        new_line(64); line_cycles(2400);
        new_line(64); line_cycles(1100);
        check("ovf512", last_period, 1024);
        line_cycles(1301);
        new_line(64); line_cycles(2100);
        check("ovf511", last_period, 1022);
        line_cycles(100);

        // Random lines, lengths, colours, en and vsync
        for (int l = 0; l < 12; l++) begin
            n = (l == 3) ? 40 : (l == 7) ? 200 : 1500 + int'($urandom_range(0, 400));
            new_line(n < 128 ? n / 2 : 64);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 599) == 0) en = ~en;
                if ($urandom_range(0, 899) == 0) vsync_in = ~vsync_in;
                line_cycles(1);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
